// File: rtl/conway_pkg.sv
// Shared types for the Conway board reader: scan FSM state encoding.
package conway_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } reader_state_t;

endpackage

// File: rtl/row_popcount.sv
// Purely combinational count of live cells in one board row.
module row_popcount #(
  parameter int unsigned COLS = 8
) (
  input  logic [COLS-1:0]            i_row,
  output logic [$clog2(COLS+1)-1:0]  o_count
);

  localparam int unsigned POP_W = $clog2(COLS + 1);

  always_comb begin
    o_count = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      o_count = o_count + POP_W'(i_row[c]);
    end
  end

endmodule

// File: rtl/conway_board_reader.sv
// Snapshots a Conway board on request and streams it row by row over a
// valid/ready channel, reporting the total live-cell count at the end.
module conway_board_reader
  import conway_pkg::*;
#(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CNT_W = $clog2(ROWS * COLS + 1),
  localparam int unsigned POP_W = $clog2(COLS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] cells,
  input  logic                 snap_req,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [COLS-1:0]      out_data,
  output logic [ROW_W-1:0]     out_row,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     live_count
);

  reader_state_t    r_state;
  reader_state_t    w_state_nxt;
  logic [COLS-1:0]  r_snap [ROWS];
  logic [ROW_W-1:0] r_row_idx;
  logic [ROW_W-1:0] w_row_nxt;
  logic [CNT_W-1:0] r_sum;
  logic [CNT_W-1:0] w_sum_nxt;
  logic [COLS-1:0]  w_data_nxt;
  logic [POP_W-1:0] w_pop;
  logic             w_load;

  // Popcount runs on the registered output row, i.e. the row being offered.
  row_popcount #(
    .COLS (COLS)
  ) u_row_popcount (
    .i_row   (out_data),
    .o_count (w_pop)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_idx;
    w_sum_nxt   = r_sum;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (snap_req) begin
          w_load      = 1'b1;
          w_row_nxt   = '0;
          w_sum_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          w_sum_nxt = r_sum + CNT_W'(w_pop);
          if (out_last) begin
            w_state_nxt = DONE;
          end else begin
            w_row_nxt = r_row_idx + 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // A fresh scan presents row 0 straight from the inputs being captured.
    w_data_nxt = w_load ? cells[COLS-1:0] : r_snap[w_row_nxt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_row_idx  <= '0;
      r_sum      <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        r_snap[r] <= '0;
      end
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      live_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_idx <= w_row_nxt;
      r_sum     <= w_sum_nxt;
      if (w_load) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          r_snap[r] <= cells[r*COLS +: COLS];
        end
      end
      out_valid <= (w_state_nxt == SEND);
      out_data  <= w_data_nxt;
      out_row   <= w_row_nxt;
      out_last  <= (w_state_nxt == SEND) && (w_row_nxt == ROW_W'(ROWS - 1));
      busy      <= (w_state_nxt != IDLE);
      done      <= (w_state_nxt == DONE);
      if (w_state_nxt == DONE) begin
        live_count <= w_sum_nxt;
      end
    end
  end

endmodule
